// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: a bank of WIDTH single-bit storage channels that share one
// clock and one runtime-selectable update mode (SR, JK, D, T). The bank adds a
// parallel load, sticky per-channel flags for the forbidden SR input S=R=1, a
// saturating counter of violating cycles, and per-bit change pulses.
// There is no handshake: every input is sampled on each rising clk edge, and
// every output comes straight from a register or its complement.
module multi_mode_ff_bank #(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter int               SR_INVALID_POLICY = 0,
    parameter int               CNT_W             = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] changed
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] viol;
    logic [WIDTH-1:0] set_only;
    logic [WIDTH-1:0] rst_only;
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] neither;
    logic             any_viol;

    // Decode each channel's a/b pair once; the SR mode builds its result from these.
    assign set_only = a & ~b;
    assign rst_only = ~a & b;
    assign both     = a & b;
    assign neither  = ~(a | b);
    assign any_viol = |viol;

    // Next-state selection. A load takes priority over the mode-driven update.
    // The S=R=1 case is flagged only when the SR update is actually applied.
    always_comb begin
        q_next = q;
        viol   = '0;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            case (mode)
                MODE_SR: begin
                    viol = both;
                    if (SR_INVALID_POLICY == 1) begin
                        // S=R=1 forces a one
                        q_next = (q & neither) | set_only | both;
                    end else if (SR_INVALID_POLICY == 2) begin
                        // S=R=1 forces a zero
                        q_next = (q & neither) | set_only;
                    end else begin
                        // S=R=1 holds, like S=R=0
                        q_next = (q & (neither | both)) | set_only;
                    end
                end
                MODE_JK: q_next = (a & ~q) | (~b & q);
                MODE_D:  q_next = a;
                MODE_T:  q_next = q ^ a;
                default: q_next = q;
            endcase
        end
    end

    // Channel state. The change pulse compares the incoming value with the current one.
    // Reset clears the pulse, so returning to RESET_VALUE never raises it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VALUE;
            changed <= '0;
        end else begin
            q       <= q_next;
            changed <= q_next ^ q;
        end
    end

    // Sticky per-channel flags. A violation in the same cycle as clr_err
    // leaves that bit set; every other bit clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= '0;
        end else if (clr_err) begin
            err <= viol;
        end else begin
            err <= err | viol;
        end
    end

    // Count cycles that contain at least one violation, not violating bits.
    // The count holds once it reaches its maximum. A clear that coincides
    // with a violation restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= any_viol ? CNT_ONE : '0;
        end else if (any_viol && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

    // The complement output is taken from the register, so it never equals q.
    assign qb = ~q;

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised bank of WIDTH single-bit storage channels. All channels share one clock and one runtime-selectable mode: SR, JK, D or T. Next generation of the team's single SR flip-flop primitive, adding:
- configurable handling of the forbidden S=R=1 input;
- sticky per-channel illegal-input flags and a saturating violation counter;
- synchronous parallel load;
- per-channel change pulses.

Used wherever the design needs a small register of control flags with latch-style set/clear semantics.

## Interface
- WIDTH, 8, number of channels (≥1)
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset
- SR_INVALID_POLICY, 0, action on S=R=1 in SR mode: 0 hold, 1 force 1, 2 force 0
- CNT_W, 8, width of violation counter (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  update enable for mode-driven update
- mode  in  2  00 SR, 01 JK, 10 D, 11 T
- a  in  WIDTH  S / J / D / T input per channel
- b  in  WIDTH  R / K input per channel; ignored in D and T modes
- load  in  1  synchronous parallel load
- load_data  in  WIDTH  value taken when load=1
- clr_err  in  1  synchronous clear of err and err_cnt
- q  out  WIDTH  channel state
- qb  out  WIDTH  always ~q
- err  out  WIDTH  sticky per-channel illegal-input flag
- err_cnt  out  CNT_W  saturating count of violating cycles
- changed  out  WIDTH  per-bit pulse: q bit changed at the last edge

## Operation
- Priority per edge: reset > load > (en and mode) > hold.
- load=1: q ← load_data regardless of en or mode. No violations are detected that cycle.
- en=0 and load=0: q holds.
- en=1, load=0, per bit i:
  - SR: a=1,b=0 → 1; a=0,b=1 → 0; 00 → hold; 11 → per SR_INVALID_POLICY.
  - JK: 10 → 1; 01 → 0; 00 → hold; 11 → toggle.
  - D: q ← a.
  - T: a=1 → toggle; else hold.
- Violation: a bit with mode=SR, en=1, load=0, a[i]=b[i]=1.
- err[i]: set on a violation of bit i; stays set until clr_err.
- clr_err with a same-cycle violation: set wins for that bit; other bits clear.
- err_cnt: +1 per cycle with at least one violating bit (not per bit). Saturates at 2^CNT_W−1.
  - clr_err alone → 0.
  - clr_err with a same-cycle violation → 1.
- changed: registered q_next ^ q. High for exactly one cycle after each change.
- qb is never equal to q on any bit, including during reset and illegal inputs.
- mode may change every cycle; no state depends on the previous mode.

## Timing
- All state updates on the rising clk edge. Inputs sampled at that edge; q visible one cycle after sampling (latency 1).
- reset assertion acts immediately, without waiting for a clock edge:
  - q = RESET_VALUE, qb = ~RESET_VALUE
  - err = 0, err_cnt = 0, changed = 0
- While reset is high, all inputs are ignored.
- First update occurs at the first rising edge after reset deasserts.
- Reset asserted mid-operation: any in-flight update is discarded; err and err_cnt are lost.
- Reset-to-RESET_VALUE does not raise changed.
- No combinational path from any input to any output.

## Test plan
Bench uses WIDTH=4, RESET_VALUE=0, SR_INVALID_POLICY=0, CNT_W=8 unless stated.
1. Reset: reset=1 at 5 ns, between edges → q=0000, qb=1111, err=0000, err_cnt=0, changed=0000, all before the next edge. Release at 10 ns → first update at the following edge.
2. SR basic: mode=00, en=1.
   - a=0001, b=0000 → q=0001, changed=0001.
   - Then a=0000, b=0001 → q=0000, changed=0001.
   - Then a=b=0000 → q holds, changed=0000.
3. SR invalid, from q=0101:
   - a=0011, b=0011 → q=0101 (hold), err=0011, err_cnt=1.
   - 3 more identical cycles → err_cnt=4.
   - clr_err=1 with a=b=0000 → err=0000, err_cnt=0.
   - Repeat with SR_INVALID_POLICY=1 → q=0111; with policy 2 → q=0100.
4. JK/T toggle: from q=0000, mode=01, a=b=1111 → q=1111, 0000, 1111 on successive edges, err stays 0000. Then mode=11, a=0110 from q=1010 → q=1100.
5. D and load priority:
   - mode=10, a=1010 → q=1010.
   - load=1, load_data=0011, en=1, a=1111 → q=0011.
   - en=0, a=0101 → q stays 0011.
6. Saturation and clear race, with CNT_W=2:
   - 5 consecutive violating cycles → err_cnt 1,2,3,3,3.
   - clr_err=1 together with a violation on bit 2 → err=0100, err_cnt=1.
